req_encoder16x4: RTL and testbench



---
 rtl/req_enc_pkg.sv | 11 +
 rtl/prio_enc16.sv | 26 ++
 rtl/req_encoder16x4.sv | 81 ++++++++
 tb/tb_req_encoder16x4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared constants for the registered request encoder: default widths and
// the two-state grant FSM encoding.
package req_enc_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int CODE_W_DEF = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage : req_enc_pkg

// File: rtl/prio_enc16.sv
// Combinational priority encoder: index of the highest set bit plus an
// any-set flag. Higher indices win.
module prio_enc16
    import req_enc_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [WIDTH-1:0]  bits,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Ascending scan: the last hit is the highest set index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bits[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : prio_enc16

// File: rtl/req_encoder16x4.sv
// Registered priority encoder with sticky pending requests and a
// valid/ack handshake; one grant is held until acknowledged.
module req_encoder16x4
    import req_enc_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [WIDTH-1:0]  pending,
    output logic              none
);

    // Handshake: valid rises with a new code and both stay frozen until a
    // cycle where valid and ack are both high; ack while valid is low has
    // no effect.

    logic [0:0]        state;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;
    logic [WIDTH-1:0]  req_gated;
    logic [WIDTH-1:0]  pend_collect;
    logic [WIDTH-1:0]  pend_release;

    prio_enc16 #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_prio (
        .bits (pending),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    assign req_gated    = req & {WIDTH{en}};
    assign pend_collect = pending | req_gated;
    // A fresh request on the granted line re-arms it over the clear.
    assign pend_release = (pending & ~(WIDTH'(1) << code)) | req_gated;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pending <= pend_collect;
                    // Selection uses pending before this edge's requests.
                    if (en && sel_any) begin
                        code  <= sel_idx;
                        valid <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ack) begin
                        pending <= pend_release;
                        valid   <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        pending <= pend_collect;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign none = (pending == '0) && !valid;

endmodule : req_encoder16x4

// File: tb/tb_req_encoder16x4.sv
// Directed bench for req_encoder16x4: a set-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_req_encoder16x4;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  req;
    logic          ack;
    logic [CW-1:0] code;
    logic          valid;
    logic [W-1:0]  pending;
    logic          none;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CW-1:0] exp_q[$];

    // Reference model: a set of waiting sources and the source being served.
    bit            m_pend[W];
    int            m_grant = -1;
    int            m_code  = 0;
    bit            model_ok = 1'b0;

    req_encoder16x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .none    (none)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_grant = -1;
            m_code  = 0;
        end else if (m_grant >= 0) begin
            if (ack) begin
                m_pend[m_grant] = 1'b0;
                m_grant = -1;
            end
            if (en) for (int i = 0; i < W; i++) if (req[i]) m_pend[i] = 1'b1;
        end else begin
            int top;
            top = -1;
            for (int i = W - 1; i >= 0; i--) if (m_pend[i] && top < 0) top = i;
            if (en) for (int i = 0; i < W; i++) if (req[i]) m_pend[i] = 1'b1;
            if (en && top >= 0) begin
                m_grant = top;
                m_code  = top;
            end
        end
        model_ok = 1'b1;
    end

    function automatic logic [W-1:0] model_pending();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_valid", 32'(valid), 32'(m_grant >= 0));
            check("cyc_code", 32'(code), 32'(m_code));
            check("cyc_pending", 32'(pending), 32'(model_pending()));
            check("cyc_none", 32'(none), 32'((model_pending() == '0) && (m_grant < 0)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [W-1:0] v);
        req = v;
        tick();
        req = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (valid !== 1'b1) check({name, "_timeout"}, 32'(valid), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0] dec;
        logic [W-1:0] onehot;
        logic [CW-1:0] exp_code;

        rst_n = 1'b0; en = 1'b0; req = '0; ack = 1'b0;
        repeat (2) tick();
        check("rst_code", 32'(code), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_none", 32'(none), 32'd1);
        rst_n = 1'b1;

        // Reset while a grant is held
        en = 1'b1;
        pulse_req(16'h0020);
        tick();
        check("midrst_pre_valid", 32'(valid), 32'd1);
        check("midrst_pre_code", 32'(code), 32'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_code", 32'(code), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_none", 32'(none), 32'd1);

        // Single request, held without ack
        pulse_req(16'h0100);
        check("single_pend", 32'(pending), 32'h0100);
        check("single_novalid", 32'(valid), 32'd0);
        tick();
        check("single_valid", 32'(valid), 32'd1);
        check("single_code", 32'(code), 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_hold", 32'({valid, code}), 32'h18);
        end
        do_ack();
        check("single_ack_valid", 32'(valid), 32'd0);
        check("single_ack_pend", 32'(pending), 32'd0);

        // Priority order
        pulse_req(16'h8421);
        exp_q = '{4'd15, 4'd10, 4'd5, 4'd0};
        while (exp_q.size() > 0) begin
            exp_code = exp_q.pop_front();
            wait_valid("prio", 4);
            check("prio_code", 32'(code), 32'(exp_code));
            do_ack();
        end
        check("prio_none", 32'(none), 32'd1);

        // Same-line re-request during ack
        req = 16'h0008;
        repeat (2) tick();
        check("rearm_code", 32'(code), 32'd3);
        do_ack();
        req = 16'h0008;
        check("rearm_pend", 32'(pending[3]), 32'd1);
        check("rearm_gap", 32'(valid), 32'd0);
        tick();
        check("rearm_valid", 32'(valid), 32'd1);
        check("rearm_code2", 32'(code), 32'd3);
        req = '0;
        do_ack();
        check("rearm_none", 32'(none), 32'd1);

        // Enable gating then full sweep 15..0
        en = 1'b0;
        req = 16'hFFFF;
        ack = 1'b1;
        repeat (3) tick();
        ack = 1'b0;
        check("gate_pend", 32'(pending), 32'd0);
        check("gate_valid", 32'(valid), 32'd0);
        check("gate_none", 32'(none), 32'd1);
        en = 1'b1;
        tick();
        req = '0;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(CW'(i));
        while (exp_q.size() > 0) begin
            exp_code = exp_q.pop_front();
            wait_valid("sweep", 4);
            check("sweep_code", 32'(code), 32'(exp_code));
            do_ack();
        end
        check("sweep_none", 32'(none), 32'd1);

        // Dropping en during a grant keeps it
        pulse_req(16'h0002);
        wait_valid("endrop", 4);
        en = 1'b0;
        repeat (3) tick();
        check("endrop_hold", 32'({valid, code}), 32'h11);
        do_ack();
        check("endrop_ack", 32'(valid), 32'd0);
        en = 1'b1;

        // Decoder round trip for every single-bit request
        for (int i = 0; i < W; i++) begin
            onehot = W'(1) << i;
            pulse_req(onehot);
            wait_valid("rt", 4);
            dec = valid ? (W'(1) << code) : '0;
            check("roundtrip", 32'(dec), 32'(onehot));
            do_ack();
        end

        // No requests at all
        repeat (6) tick();
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_none", 32'(none), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_req_encoder16x4
